// File: rtl/pkt_cls_pkg.sv
// Shared classifier types: field/rule-ID defaults, set and config width helpers, commit states, cfg_sel codes.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package pkt_cls_pkg;

  localparam int DEF_FIELD_WIDTH   = 32;
  localparam int DEF_NUM_RULE_ID   = 8;
  localparam int DEF_RULE_ID_WIDTH = 3;

  // cfg_sel encodings
  localparam logic CFG_SEL_NODE = 1'b0;
  localparam logic CFG_SEL_LEAF = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } commit_state_t;

  // Width of one rule-ID set: every slot is {valid, id}.
  function automatic int set_w(input int num_rule_id, input int rule_id_width);
    return num_rule_id * (1 + rule_id_width);
  endfunction

  // Config write data must hold either a threshold or a leaf set.
  function automatic int cfg_dw(input int field_width, input int set_width);
    return (field_width > set_width) ? field_width : set_width;
  endfunction

endpackage

// File: rtl/rmt_level.sv
// One compare level of the range-match tree: holds 2^LEVEL active/shadow thresholds, steers the token.
// Latency: 1 cycle, token registered.
// Backpressure: none; the level never stalls, admission is gated upstream.
module rmt_level
  import pkt_cls_pkg::*;
#(
  parameter int FIELD_WIDTH = DEF_FIELD_WIDTH,
  parameter int LEVELS      = 4,
  parameter int LEVEL       = 0,
  parameter int CFG_DW      = DEF_FIELD_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   prev_vld,
  input  logic [FIELD_WIDTH-1:0] prev_key,
  input  logic [LEVELS-1:0]      prev_idx,
  input  logic                   cfg_we,
  input  logic                   cfg_sel,
  input  logic [LEVELS-1:0]      cfg_addr,
  input  logic [CFG_DW-1:0]      cfg_wdata,
  input  logic                   swap,
  output logic                   vld,
  output logic [FIELD_WIDTH-1:0] key,
  output logic [LEVELS-1:0]      idx
);

  localparam int NODES = 1 << LEVEL;
  localparam int BASE  = NODES - 1;   // heap index of this level's first node

  logic [FIELD_WIDTH-1:0] act_thr [NODES];
  logic [FIELD_WIDTH-1:0] shd_thr [NODES];
  logic [FIELD_WIDTH-1:0] thr;
  logic                   go_right;

  // Select the active threshold of the node the token currently sits on.
  always_comb begin
    thr = '0;
    for (int n = 0; n < NODES; n++) begin
      if (prev_idx == LEVELS'(n)) thr = act_thr[n];
    end
  end

  assign go_right = (prev_key >= thr);

  // Shadow writes land in any state; swap copies the pre-edge shadow image.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NODES; n++) begin
        act_thr[n] <= '0;
        shd_thr[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NODES; n++) begin
        if (cfg_we && (cfg_sel == CFG_SEL_NODE) && (cfg_addr == LEVELS'(BASE + n)))
          shd_thr[n] <= cfg_wdata[FIELD_WIDTH-1:0];
        if (swap)
          act_thr[n] <= shd_thr[n];
      end
    end
  end

  // Advance the token one level, appending this level's branch bit to the index.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= 1'b0;
      key <= '0;
      idx <= '0;
    end else begin
      vld <= prev_vld;
      key <= prev_key;
      idx <= (prev_idx << 1) | LEVELS'(go_right);
    end
  end

endmodule

// File: rtl/range_match_tree_param.sv
// Pipelined range-match tree: key -> LEVELS threshold compares -> leaf rule-ID set; optional hit counters (RMT_HIT_COUNT_EN).
// Latency: LEVELS+2 cycles from acceptance to out_valid; one lookup per cycle.
// Backpressure: in_ready drops during a commit (drain + swap); an offered key is held upstream until accepted.
module range_match_tree_param
  import pkt_cls_pkg::*;
#(
  parameter int FIELD_WIDTH   = DEF_FIELD_WIDTH,
  parameter int NUM_RULE_ID   = DEF_NUM_RULE_ID,
  parameter int RULE_ID_WIDTH = DEF_RULE_ID_WIDTH,
  parameter int LEVELS        = 4,
  localparam int SET_W  = set_w(NUM_RULE_ID, RULE_ID_WIDTH),
  localparam int CFG_DW = cfg_dw(FIELD_WIDTH, SET_W)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [FIELD_WIDTH:0] in,
  output logic                 in_ready,
  output logic [SET_W-1:0]     out,
  output logic                 out_valid,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [LEVELS-1:0]    cfg_addr,
  input  logic [CFG_DW-1:0]    cfg_wdata,
  input  logic                 cfg_commit,
  output logic                 cfg_busy
`ifdef RMT_HIT_COUNT_EN
  ,
  input  logic [LEVELS-1:0]    stat_addr,
  output logic [15:0]          stat_data,
  input  logic                 stat_clear
`endif
);

  localparam int NUM_LEAVES = 1 << LEVELS;

  commit_state_t state, state_nxt;
  logic swap;
  logic pipe_busy;

  logic                   ir_vld;
  logic [FIELD_WIDTH-1:0] ir_key;

  logic                   s_vld [LEVELS];
  logic [FIELD_WIDTH-1:0] s_key [LEVELS];
  logic [LEVELS-1:0]      s_idx [LEVELS];

  logic [SET_W-1:0] act_leaf [NUM_LEAVES];
  logic [SET_W-1:0] shd_leaf [NUM_LEAVES];

  logic              leaf_vld;
  logic [LEVELS-1:0] leaf_idx;
  logic              unused_last_key;

  assign leaf_vld        = s_vld[LEVELS-1];
  assign leaf_idx        = s_idx[LEVELS-1];
  assign unused_last_key = ^s_key[LEVELS-1];

  // Any valid token in the input register or a compare level keeps a commit draining.
  always_comb begin
    pipe_busy = ir_vld;
    for (int l = 0; l < LEVELS; l++) pipe_busy = pipe_busy | s_vld[l];
  end

  // Commit state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Commit next-state and outputs; commits arriving while busy merge into the pending one.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cfg_busy  = 1'b1;
    swap      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        cfg_busy = 1'b0;
        if (cfg_commit) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pipe_busy) state_nxt = ST_SWAP;
      end
      ST_SWAP: begin
        swap      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Input register: only a key offered while idle enters the tree.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_vld <= 1'b0;
      ir_key <= '0;
    end else begin
      ir_vld <= in[FIELD_WIDTH] && in_ready;
      ir_key <= in[FIELD_WIDTH-1:0];
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    if (l == 0) begin : g_root
      rmt_level #(
        .FIELD_WIDTH(FIELD_WIDTH), .LEVELS(LEVELS), .LEVEL(0), .CFG_DW(CFG_DW)
      ) u_level (
        .clk(clk), .reset(reset),
        .prev_vld(ir_vld), .prev_key(ir_key), .prev_idx(LEVELS'(0)),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .swap(swap),
        .vld(s_vld[0]), .key(s_key[0]), .idx(s_idx[0])
      );
    end else begin : g_inner
      rmt_level #(
        .FIELD_WIDTH(FIELD_WIDTH), .LEVELS(LEVELS), .LEVEL(l), .CFG_DW(CFG_DW)
      ) u_level (
        .clk(clk), .reset(reset),
        .prev_vld(s_vld[l-1]), .prev_key(s_key[l-1]), .prev_idx(s_idx[l-1]),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .swap(swap),
        .vld(s_vld[l]), .key(s_key[l]), .idx(s_idx[l])
      );
    end
  end

  // Leaf set tables: shadow written any time, copied to active on the swap edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_LEAVES; n++) begin
        act_leaf[n] <= '0;
        shd_leaf[n] <= '0;
      end
    end else begin
      if (cfg_we && (cfg_sel == CFG_SEL_LEAF))
        shd_leaf[cfg_addr] <= cfg_wdata[SET_W-1:0];
      if (swap) begin
        for (int n = 0; n < NUM_LEAVES; n++) act_leaf[n] <= shd_leaf[n];
      end
    end
  end

  // Output register: the reached leaf's set verbatim, zero for an empty slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= leaf_vld;
      out       <= leaf_vld ? act_leaf[leaf_idx] : '0;
    end
  end

`ifdef RMT_HIT_COUNT_EN
  logic [15:0] hit_cnt [NUM_LEAVES];

  // Per-leaf saturating hit counters, bumped as each result is registered.
  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      for (int n = 0; n < NUM_LEAVES; n++) hit_cnt[n] <= '0;
    end else if (leaf_vld && (hit_cnt[leaf_idx] != 16'hFFFF)) begin
      hit_cnt[leaf_idx] <= hit_cnt[leaf_idx] + 16'd1;
    end
  end

  // Registered statistics read port.
  always_ff @(posedge clk) begin
    if (reset) stat_data <= '0;
    else       stat_data <= hit_cnt[stat_addr];
  end
`endif

endmodule
